// File: rtl/clk_switch_ctrl.sv
// ---------------------------------------------------------------------------
// clk_switch_ctrl
//   Sequencer that drives the select input of an N-way glitch-free clock mux.
//   Software requests a new clock over a valid/ready handshake; after the
//   select changes, the controller waits a settle window before the new
//   select is reported as current. When the active clock is flagged as
//   failed, the controller can move to the lowest-index healthy clock on
//   its own. If every clock has failed, it parks in HOLD until one recovers.
//   The block runs on an always-on reference clock. clk_fail is expected to
//   be synchronous to clk already.
//
// Ports
//   clk        in   reference clock, all logic on posedge
//   rst_n      in   synchronous reset, active low
//   clk_fail   in   [CLK_NUM] per-clock fail flags (level)
//   req_valid  in   switch request valid
//   req_sel    in   [SEL_W] requested clock index
//   req_ready  out  request accepted when req_valid & req_ready
//   req_err    out  1-cycle pulse: accepted request rejected or dropped
//   req_done   out  1-cycle pulse: accepted request completed
//   sel_out    out  [SEL_W] select driven to the clock mux (registered)
//   cur_sel    out  [SEL_W] last settled select (registered)
//   busy       out  controller is not idle
//   failover   out  1-cycle pulse when hardware starts a failover
//   all_fail   out  every clock failed, controller holding
// ---------------------------------------------------------------------------
module clk_switch_ctrl #(
    parameter int CLK_NUM       = 4,
    parameter int SEL_W         = $clog2(CLK_NUM),
    parameter int SETTLE_CYC    = 8,
    parameter int DEF_SEL       = 0,
    parameter int AUTO_FAILOVER = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CLK_NUM-1:0] clk_fail,
    input  logic               req_valid,
    input  logic [SEL_W-1:0]   req_sel,
    output logic               req_ready,
    output logic               req_err,
    output logic               req_done,
    output logic [SEL_W-1:0]   sel_out,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               busy,
    output logic               failover,
    output logic               all_fail
);

    localparam int                CNT_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0]  SEL_RST  = SEL_W'(DEF_SEL);
    localparam logic              AF_EN    = (AUTO_FAILOVER != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pending;

    logic [SEL_W-1:0] tgt;
    logic             none_ok;
    logic             cur_fail;
    logic             sel_fail;
    logic             req_bad;
    logic             fail_now;
    logic             accept;

    // An index outside the clock range counts as failed. That makes the
    // range check and the health check of a request a single lookup.
    function automatic logic fail_bit(input logic [SEL_W-1:0]   idx,
                                      input logic [CLK_NUM-1:0] flags);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < CLK_NUM; i++) begin
            if (idx == SEL_W'(i)) begin
                r = flags[i];
            end
        end
        return r;
    endfunction

    always_comb begin
        // Scan from the top down so that the lowest healthy index wins.
        tgt = '0;
        for (int unsigned i = CLK_NUM; i > 0; i--) begin
            if (!clk_fail[i-1]) begin
                tgt = SEL_W'(i - 1);
            end
        end
        none_ok   = &clk_fail;
        cur_fail  = fail_bit(cur_sel, clk_fail);
        sel_fail  = fail_bit(sel_out, clk_fail);
        req_bad   = fail_bit(req_sel, clk_fail);
        fail_now  = AF_EN & cur_fail;
        req_ready = (state == ST_IDLE) & ~fail_now;
        accept    = req_valid & req_ready;
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sel_out  <= SEL_RST;
            cur_sel  <= SEL_RST;
            cnt      <= '0;
            pending  <= 1'b0;
            req_err  <= 1'b0;
            req_done <= 1'b0;
            failover <= 1'b0;
            all_fail <= 1'b0;
        end else begin
            req_err  <= 1'b0;
            req_done <= 1'b0;
            failover <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fail_now) begin
                        if (!none_ok) begin
                            sel_out  <= tgt;
                            cnt      <= CNT_LOAD;
                            failover <= 1'b1;
                            state    <= ST_SETTLE;
                        end else begin
                            all_fail <= 1'b1;
                            state    <= ST_HOLD;
                        end
                    end else if (accept) begin
                        if (req_bad) begin
                            req_err <= 1'b1;
                        end else if (req_sel == cur_sel) begin
                            req_done <= 1'b1;
                        end else begin
                            sel_out <= req_sel;
                            cnt     <= CNT_LOAD;
                            pending <= 1'b1;
                            state   <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    // A failure of the clock being settled outranks the
                    // settle completing in the same cycle.
                    if (AF_EN && sel_fail) begin
                        req_err <= pending;
                        pending <= 1'b0;
                        if (!none_ok) begin
                            sel_out  <= tgt;
                            cnt      <= CNT_LOAD;
                            failover <= 1'b1;
                        end else begin
                            all_fail <= 1'b1;
                            state    <= ST_HOLD;
                        end
                    end else if (cnt == '0) begin
                        cur_sel  <= sel_out;
                        req_done <= pending;
                        pending  <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!none_ok) begin
                        sel_out  <= tgt;
                        cnt      <= CNT_LOAD;
                        failover <= 1'b1;
                        all_fail <= 1'b0;
                        state    <= ST_SETTLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_switch_ctrl
//   Self-checking bench for clk_switch_ctrl.
//   dut_a uses the default parameters. Every cycle it is compared against a
//   behavioural model, first under directed scenarios and then under random
//   stimulus.
//   dut_b uses 5 clocks, a 3-cycle settle window, DEF_SEL=4 and failover
//   disabled. It covers out-of-range indices and report-only mode with
//   directed checks.
// ---------------------------------------------------------------------------
module tb_clk_switch_ctrl;

    localparam int N      = 4;
    localparam int SETTLE = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a
    logic         rst_n;
    logic [3:0]   clk_fail;
    logic         req_valid;
    logic [1:0]   req_sel;
    logic         req_ready, req_err, req_done, busy, failover, all_fail;
    logic [1:0]   sel_out, cur_sel;

    // dut_b
    logic         rst_n_b;
    logic [4:0]   clk_fail_b;
    logic         req_valid_b;
    logic [2:0]   req_sel_b;
    logic         req_ready_b, req_err_b, req_done_b, busy_b, failover_b, all_fail_b;
    logic [2:0]   sel_out_b, cur_sel_b;

    clk_switch_ctrl dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_fail  (clk_fail),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .req_err   (req_err),
        .req_done  (req_done),
        .sel_out   (sel_out),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .failover  (failover),
        .all_fail  (all_fail)
    );

    clk_switch_ctrl #(
        .CLK_NUM       (5),
        .SETTLE_CYC    (3),
        .DEF_SEL       (4),
        .AUTO_FAILOVER (0)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n_b),
        .clk_fail  (clk_fail_b),
        .req_valid (req_valid_b),
        .req_sel   (req_sel_b),
        .req_ready (req_ready_b),
        .req_err   (req_err_b),
        .req_done  (req_done_b),
        .sel_out   (sel_out_b),
        .cur_sel   (cur_sel_b),
        .busy      (busy_b),
        .failover  (failover_b),
        .all_fail  (all_fail_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference model. Settling is tracked as the number of SETTLE cycles
    // still to go, where 0 means not settling.
    int m_sel, m_cur, m_left;
    bit m_hold, m_pend, m_err, m_done, m_fo;

    function automatic int first_ok(input logic [3:0] f);
        for (int i = 0; i < N; i++) if (!f[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_sel = 0; m_cur = 0; m_left = 0;
        m_hold = 0; m_pend = 0; m_err = 0; m_done = 0; m_fo = 0;
    endtask

    task automatic model_step(input bit rn, input logic [3:0] f, input bit v, input int s);
        int ok;
        ok = first_ok(f);
        if (!rn) begin
            model_reset();
            return;
        end
        m_err = 0; m_done = 0; m_fo = 0;
        if (m_hold) begin
            if (ok >= 0) begin
                m_hold = 0; m_sel = ok; m_left = SETTLE; m_fo = 1;
            end
        end else if (m_left > 0) begin
            if (f[m_sel]) begin
                m_err = m_pend; m_pend = 0;
                if (ok >= 0) begin
                    m_sel = ok; m_left = SETTLE; m_fo = 1;
                end else begin
                    m_left = 0; m_hold = 1;
                end
            end else if (m_left == 1) begin
                m_left = 0; m_cur = m_sel; m_done = m_pend; m_pend = 0;
            end else begin
                m_left--;
            end
        end else begin
            if (f[m_cur]) begin
                if (ok >= 0) begin
                    m_sel = ok; m_left = SETTLE; m_fo = 1;
                end else begin
                    m_hold = 1;
                end
            end else if (v) begin
                if (s >= N || f[s]) m_err = 1;
                else if (s == m_cur) m_done = 1;
                else begin
                    m_sel = s; m_left = SETTLE; m_pend = 1;
                end
            end
        end
    endtask

    int obs_sel, obs_cur, obs_busy;
    bit obs_done, obs_err, obs_fo, obs_all;

    // One clock cycle on dut_a: drive inputs at negedge, compare all outputs
    // with the model, then advance the model over the coming posedge.
    task automatic cycle(input bit rn, input logic [3:0] f, input bit v, input logic [1:0] s);
        bit idle;
        @(negedge clk);
        rst_n = rn; clk_fail = f; req_valid = v; req_sel = s;
        #1;
        idle = !m_hold && (m_left == 0);
        check("sel_out",   sel_out,   m_sel);
        check("cur_sel",   cur_sel,   m_cur);
        check("busy",      busy,      int'(!idle));
        check("req_ready", req_ready, int'(idle && !f[m_cur]));
        check("req_err",   req_err,   m_err);
        check("req_done",  req_done,  m_done);
        check("failover",  failover,  m_fo);
        check("all_fail",  all_fail,  m_hold);
        obs_sel = sel_out; obs_cur = cur_sel; obs_busy = busy;
        obs_done = req_done; obs_err = req_err; obs_fo = failover; obs_all = all_fail;
        model_step(rn, f, v, int'(s));
    endtask

    task automatic step_b(input bit rn, input logic [4:0] f, input bit v, input logic [2:0] s);
        @(negedge clk);
        rst_n_b = rn; clk_fail_b = f; req_valid_b = v; req_sel_b = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        logic [3:0] rf;

        rst_n = 0; clk_fail = '0; req_valid = 0; req_sel = '0;
        rst_n_b = 0; clk_fail_b = '0; req_valid_b = 0; req_sel_b = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // T1: reset state
        cycle(0, 4'b0000, 0, 0);
        cycle(1, 4'b0000, 0, 0);
        check("t1_ready", obs_sel == 0 && req_ready, 1);

        // T2: request 2, settle latency
        cycle(1, 4'b0000, 1, 2);
        lat = -1;
        for (int k = 1; k <= 14; k++) begin
            cycle(1, 4'b0000, 0, 0);
            if (k == 1) check("t2_sel_next", obs_sel, 2);
            if (obs_done && lat < 0) lat = k;
        end
        check("t2_latency", lat, 9);
        check("t2_cur", obs_cur, 2);

        // T3: request for a failed clock
        cycle(0, 4'b0000, 0, 0);
        cycle(1, 4'b0010, 1, 1);
        cycle(1, 4'b0010, 0, 0);
        check("t3_err", obs_err, 1);
        check("t3_sel", obs_sel, 0);
        // same-index request completes in one cycle
        cycle(1, 4'b0000, 1, 0);
        cycle(1, 4'b0000, 0, 0);
        check("t3_noop_done", obs_done, 1);

        // T4: active clock fails together with a request
        cycle(1, 4'b0001, 1, 3);
        cycle(1, 4'b0001, 0, 0);
        check("t4_failover", obs_fo, 1);
        check("t4_sel", obs_sel, 1);
        repeat (10) cycle(1, 4'b0001, 0, 0);

        // T5: target fails mid-settle
        cycle(1, 4'b0001, 1, 3);
        repeat (3) cycle(1, 4'b0001, 0, 0);
        cycle(1, 4'b1001, 0, 0);
        cycle(1, 4'b1001, 0, 0);
        check("t5_err", obs_err, 1);
        check("t5_sel", obs_sel, 1);
        check("t5_failover", obs_fo, 1);
        repeat (10) cycle(1, 4'b1001, 0, 0);

        // T6: all clocks failed, then one recovers
        cycle(1, 4'b1111, 0, 0);
        repeat (4) cycle(1, 4'b1111, 0, 0);
        check("t6_all_fail", obs_all, 1);
        cycle(1, 4'b1011, 0, 0);
        cycle(1, 4'b1011, 0, 0);
        check("t6_sel", obs_sel, 2);
        check("t6_failover", obs_fo, 1);
        repeat (8) cycle(1, 4'b1011, 0, 0);
        check("t6_cur", obs_cur, 2);
        // reset in the middle of a settle
        cycle(1, 4'b0000, 1, 0);
        repeat (3) cycle(1, 4'b0000, 0, 0);
        cycle(0, 4'b0000, 0, 0);
        cycle(1, 4'b0000, 0, 0);
        check("t6_rst_busy", obs_busy, 0);
        check("t6_rst_sel", obs_sel, 0);

        // Random stimulus
        rf = '0;
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 7))
                    0:       rf = 4'b1111;
                    1, 2:    rf = 4'b0000;
                    default: rf = 4'($urandom_range(0, 15));
                endcase
            end
            cycle($urandom_range(0, 299) != 0, rf, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)));
        end

        // dut_b: 5 clocks, settle 3, DEF_SEL 4, report-only
        step_b(0, 5'b00000, 0, 0);
        check("b_rst_sel", sel_out_b, 4);
        check("b_rst_cur", cur_sel_b, 4);
        check("b_rst_busy", busy_b, 0);
        check("b_rst_ready", req_ready_b, 1);
        step_b(1, 5'b00000, 1, 7);
        check("b_bad_idx_err", req_err_b, 1);
        check("b_bad_idx_sel", sel_out_b, 4);
        step_b(1, 5'b00100, 1, 2);
        check("b_failed_tgt_err", req_err_b, 1);
        step_b(1, 5'b00000, 1, 1);
        check("b_acc_sel", sel_out_b, 1);
        check("b_acc_busy", busy_b, 1);
        step_b(1, 5'b00000, 0, 0);
        check("b_settle_done1", req_done_b, 0);
        step_b(1, 5'b00000, 0, 0);
        check("b_settle_done2", req_done_b, 0);
        step_b(1, 5'b00000, 0, 0);
        check("b_done", req_done_b, 1);
        check("b_cur", cur_sel_b, 1);
        check("b_idle", busy_b, 0);
        step_b(1, 5'b00010, 0, 0);
        check("b_no_failover", failover_b, 0);
        check("b_no_busy", busy_b, 0);
        check("b_ready_kept", req_ready_b, 1);
        check("b_sel_kept", sel_out_b, 1);
        step_b(1, 5'b00010, 1, 1);
        check("b_cur_failed_err", req_err_b, 1);
        check("b_cur_failed_done", req_done_b, 0);
        step_b(1, 5'b11111, 0, 0);
        check("b_no_all_fail", all_fail_b, 0);
        check("b_no_hold", busy_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
